stream_stall_fifo: RTL
======================

STREAM_STALL_FIFO -- requirements
Module: stream_stall_fifo

Interface
REQ-001 Parameter WIDTH, default 32, data word width in bits, legal range 1 to 512.
REQ-002 Parameter DEPTH, default 8, number of storage entries, a power of two and at least 2.
REQ-003 Parameter ALMOST_FULL, default 6, occupancy at which upstream_stall asserts, legal range 1 to DEPTH.
REQ-004 Port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1 bit: synchronous, active-low reset.
REQ-006 Port in_data, input, WIDTH bits: producer data word.
REQ-007 Port in_valid, input, 1 bit: in_data holds a word this cycle.
REQ-008 Port upstream_stall, output, 1 bit: producer is asked to hold.
REQ-009 Port out_data, output, WIDTH bits: head-of-queue word.
REQ-010 Port out_valid, output, 1 bit: out_data is valid.
REQ-011 Port downstream_stall, input, 1 bit: consumer cannot take a word this cycle.
REQ-012 Port flush, input, 1 bit: synchronous discard of all queued words.
REQ-013 Port count, output, clog2(DEPTH+1) bits: current occupancy.
REQ-014 Port max_count, output, clog2(DEPTH+1) bits: high-water mark of count since reset.
REQ-015 Port overflow, output, 1 bit: sticky flag for a dropped word.

Function
REQ-016 Definitions, evaluated on the same cycle: pop = out_valid and not downstream_stall; push = in_valid and (count < DEPTH or pop).
REQ-017 Data SHALL be stored in a circular buffer with write and read pointers of clog2(DEPTH) bits that wrap from DEPTH-1 to 0.
REQ-018 Output SHALL be first-word-fall-through: out_valid = (count != 0), and out_data = mem[rd_ptr] combinationally.
REQ-019 Latency: a word pushed at edge k SHALL appear on out_data with out_valid high in the cycle after edge k if the queue was empty.
REQ-020 Words SHALL exit in exactly the order accepted, with no duplication or loss except as defined in REQ-023.
REQ-021 Count update per edge: +1 on push only; -1 on pop only; unchanged on both or neither.
REQ-022 upstream_stall SHALL be registered, and SHALL equal (count_next >= ALMOST_FULL) after each edge, giving DEPTH-ALMOST_FULL words of slack.
REQ-023 If in_valid is high while count == DEPTH and pop is low, the word SHALL be dropped and overflow SHALL set at that edge.
REQ-024 Overflow SHALL stay set until reset; flush does not clear it.
REQ-025 Simultaneous push and pop at count == DEPTH SHALL be accepted; count stays DEPTH and no overflow occurs.
REQ-026 Simultaneous push and pop at count == 0 cannot occur, because pop requires out_valid; the word is written and count becomes 1.
REQ-027 Flush high at an edge SHALL zero the pointers and count and clear upstream_stall.
REQ-028 During a flush cycle, push, pop and overflow detection SHALL be ignored in that cycle; max_count is unaffected.
REQ-029 max_count SHALL update to count_next whenever count_next exceeds it.
REQ-030 out_data while out_valid is low is don't-care; a checker SHALL NOT compare it.

Reset
REQ-031 While reset is 0 at an edge, the block SHALL zero the pointers, count and max_count, and clear overflow and upstream_stall.
REQ-032 Reset SHALL take priority over flush, push and pop.
REQ-033 Storage contents need not be cleared on reset.
REQ-034 After reset releases, the first edge with reset = 1 SHALL accept a push.
REQ-035 Reset asserted mid-stream SHALL discard all queued words; out_valid reads 0 the cycle after the reset edge.

Verification (WIDTH=32, DEPTH=8, ALMOST_FULL=6)
REQ-036 Reset hold: reset=0 for 5 edges with in_valid=1 -> out_valid=0, count=0, upstream_stall=0, overflow=0 throughout.
REQ-037 Passthrough: downstream_stall=0, push 0x00000001..0x00000010 on consecutive cycles -> same 16 words out in order, each 1 cycle after input, count never above 1.
REQ-038 Fill and stall: downstream_stall=1, push 8 words -> upstream_stall rises after the 6th push, count=8, max_count=8; a 9th in_valid sets overflow and count stays 8.
REQ-039 Full with simultaneous push and pop: count=8, downstream_stall=0, in_valid=1 with 0xAAAA5555 -> count stays 8, no overflow, and 0xAAAA5555 exits 8 pops later.
REQ-040 Flush: count=5, assert flush with in_valid=1 for one edge -> count=0, out_valid=0, the pushed word is discarded, max_count unchanged at 5, overflow unchanged.
REQ-041 Wrap and reset mid-operation: run 20 random push/pop cycles through pointer wrap against a reference queue, then assert reset=0 at count=3 -> count=0, max_count=0, overflow=0 on the next cycle.

Source files
------------

// File: rtl/stream_stall_fifo.sv
// stream_stall_fifo
//   First-word-fall-through FIFO that carries a stream between a producer that
//   obeys a registered stall and a consumer that can stall on any cycle. The
//   block also keeps an occupancy high-water mark and a sticky overflow flag.
//
// Ports
//   clock            : single clock; all state changes on its rising edge
//   reset            : synchronous, active-low; overrides flush, push and pop
//   in_data/in_valid : producer word and its qualifier
//   upstream_stall   : registered request for the producer to hold
//   out_data         : head-of-queue word (meaningful only while out_valid)
//   out_valid        : queue is non-empty
//   downstream_stall : consumer cannot take the head word this cycle
//   flush            : synchronous discard of every queued word
//   count            : current occupancy
//   max_count        : largest occupancy since reset
//   overflow         : sticky; set when a word was dropped because the queue was full
//
// Handshake
//   A word transfers out (pop) on any edge where out_valid=1 and
//   downstream_stall=0. A word transfers in (push) on any edge where in_valid=1
//   and there is room, counting the slot that a same-cycle pop frees.
//   upstream_stall is advisory: it rises once occupancy reaches ALMOST_FULL,
//   leaving DEPTH-ALMOST_FULL slots for words the producer already launched.
//   A word offered while the queue is full and not popping is dropped and
//   recorded in overflow.
module stream_stall_fifo #(
  parameter int WIDTH       = 32,
  parameter int DEPTH       = 8,
  parameter int ALMOST_FULL = 6
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_valid,
  output logic                       upstream_stall,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       downstream_stall,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [$clog2(DEPTH+1)-1:0] max_count,
  output logic                       overflow
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count_next;
  logic             full;
  logic             pop;
  logic             push;
  logic             drop;

  assign full = (count == CW'(DEPTH));
  assign pop  = out_valid && !downstream_stall;
  // A full queue still accepts a word when the head leaves on the same edge.
  assign push = in_valid && (!full || pop);
  assign drop = in_valid && full && !pop;

  always_comb begin
    count_next = count;
    if (push && !pop) begin
      count_next = count + CW'(1);
    end else if (pop && !push) begin
      count_next = count - CW'(1);
    end
  end

  // Pointers are exactly PW bits wide and DEPTH is a power of two, so the
  // natural increment wraps DEPTH-1 back to 0.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      max_count      <= '0;
      overflow       <= 1'b0;
      upstream_stall <= 1'b0;
    end else if (flush) begin
      // Flush drops the queue but keeps the history (max_count, overflow).
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      upstream_stall <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count          <= count_next;
      upstream_stall <= (count_next >= CW'(ALMOST_FULL));
      if (count_next > max_count) begin
        max_count <= count_next;
      end
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

  // Storage is not reset; out_valid masks whatever it holds.
  always_ff @(posedge clock) begin
    if (reset && !flush && push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  assign out_valid = (count != '0);
  assign out_data  = mem[rd_ptr];

endmodule
